// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_digits(input int width, input int digit_w);
        return width / digit_w;
    endfunction

    // A single-digit compare still needs a 1-bit index register.
    function automatic int calc_idx_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT_W-bit digit pair.
module digit_cmp #(
    parameter int DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] a_i,
    input  logic [DIGIT_W-1:0] b_i,
    output logic               eq_o,
    output logic               gt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator, MSB digit first, start/done handshake.
// SEQCMP_EARLY_EXIT_EN: leave RUN on the first differing digit instead of scanning all digits.
module seq_magnitude_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2,
    parameter int SIGNED  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int D     = calc_digits(WIDTH, DIGIT_W);
    localparam int IDX_W = calc_idx_w(D);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if ((DIGIT_W < 1) || (DIGIT_W > WIDTH) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_cfg
        $fatal(1, "seq_magnitude_comparator: WIDTH must be a multiple of DIGIT_W");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    int               shamt;
    logic [DIGIT_W-1:0] a_dig, b_dig;
    logic             dig_eq, dig_gt;

    assign shamt = int'(idx_q) * DIGIT_W;
    assign a_dig = DIGIT_W'(a_q >> shamt);
    assign b_dig = DIGIT_W'(b_q >> shamt);

    digit_cmp #(
        .DIGIT_W(DIGIT_W)
    ) u_digit_cmp (
        .a_i (a_dig),
        .b_i (b_dig),
        .eq_o(dig_eq),
        .gt_o(dig_gt)
    );

`ifndef SEQCMP_EARLY_EXIT_EN
    // First differing digit wins; later digits only matter while still undecided.
    logic dec_q, dec_d;
    logic dec_gt_q, dec_gt_d;
    logic verdict_dec, verdict_gt;

    assign verdict_dec = dec_q | ~dig_eq;
    assign verdict_gt  = dec_q ? dec_gt_q : dig_gt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q    <= 1'b0;
            dec_gt_q <= 1'b0;
        end else begin
            dec_q    <= dec_d;
            dec_gt_q <= dec_gt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
`ifndef SEQCMP_EARLY_EXIT_EN
        dec_d    = dec_q;
        dec_gt_d = dec_gt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a ^ SIGN_FLIP;
                    b_d     = b ^ SIGN_FLIP;
                    idx_d   = IDX_LAST;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = RUN;
`ifndef SEQCMP_EARLY_EXIT_EN
                    dec_d    = 1'b0;
                    dec_gt_d = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef SEQCMP_EARLY_EXIT_EN
                if (!dig_eq) begin
                    gt_d    = dig_gt;
                    lt_d    = ~dig_gt;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                if (idx_q == '0) begin
                    if (verdict_dec) begin
                        gt_d = verdict_gt;
                        lt_d = ~verdict_gt;
                    end else begin
                        eq_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q - IDX_W'(1);
                    dec_d    = verdict_dec;
                    dec_gt_d = verdict_gt;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: eight comparator configurations driven in lockstep against an arithmetic model.
module tb_seq_magnitude_comparator;

    localparam int NI = 8;
    localparam int P_W  [NI] = '{8, 8, 4, 4, 4, 4, 4, 4};
    localparam int P_DW [NI] = '{2, 2, 1, 2, 4, 1, 2, 4};
    localparam int P_S  [NI] = '{0, 1, 0, 0, 0, 1, 1, 1};
`ifdef SEQCMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    a_drv, b_drv;
    logic [NI-1:0] busy_w, done_w, eq_w, gt_w, lt_w;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_res [NI];
    int         exp_lat [NI];
    logic [2:0] obs_res [NI];
    int         obs_lat [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        seq_magnitude_comparator #(
            .WIDTH  (P_W[gi]),
            .DIGIT_W(P_DW[gi]),
            .SIGNED (P_S[gi])
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start),
            .a    (a_drv[P_W[gi]-1:0]),
            .b    (b_drv[P_W[gi]-1:0]),
            .busy (busy_w[gi]),
            .done (done_w[gi]),
            .eq   (eq_w[gi]),
            .gt   (gt_w[gi]),
            .lt   (lt_w[gi])
        );
    end

    // Result {eq,gt,lt} from integer values; latency from the first differing digit.
    function automatic void model(input int i, input logic [7:0] av, input logic [7:0] bv,
                                  output logic [2:0] res, output int lat);
        int w, dw, nd, ua, ub, sa, sb, da, db;
        bit found;
        w  = P_W[i];
        dw = P_DW[i];
        nd = w / dw;
        ua = int'(av) & ((1 << w) - 1);
        ub = int'(bv) & ((1 << w) - 1);
        sa = ua;
        sb = ub;
        if (P_S[i] != 0) begin
            if (ua >= (1 << (w - 1))) sa = ua - (1 << w);
            if (ub >= (1 << (w - 1))) sb = ub - (1 << w);
        end
        if (sa == sb)     res = 3'b100;
        else if (sa > sb) res = 3'b010;
        else              res = 3'b001;
        lat   = nd;
        found = 1'b0;
        if (EARLY) begin
            for (int k = 0; k < nd; k++) begin
                da = (ua >> ((nd - 1 - k) * dw)) & ((1 << dw) - 1);
                db = (ub >> ((nd - 1 - k) * dw)) & ((1 << dw) - 1);
                if (!found && da != db) begin
                    lat   = k + 1;
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(input string name, input int i, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s inst=%0d got{busy,done,eq,gt,lt}=%b want=%b t=%0t", name, i, got, want, $time);
        end
    endtask

    task automatic check_lit(input string name, input int i, input logic [2:0] want_res, input int want_lat);
        checks++;
        if (exp_res[i] !== want_res || exp_lat[i] != want_lat) begin
            failures++;
            $display("FAIL model_%s inst=%0d model res=%b lat=%0d want res=%b lat=%0d",
                     name, i, exp_res[i], exp_lat[i], want_res, want_lat);
        end
        checks++;
        if (obs_res[i] !== want_res || obs_lat[i] != want_lat) begin
            failures++;
            $display("FAIL dut_%s inst=%0d got res=%b lat=%0d want res=%b lat=%0d",
                     name, i, obs_res[i], obs_lat[i], want_res, want_lat);
        end
    endtask

    // One operation on all instances; every cycle after the accepting edge is compared.
    task automatic run_op(input logic [7:0] a0, input logic [7:0] b0, input bit hold);
        int minl, maxl;
        logic [4:0] got, want;
        @(negedge clk);
        a_drv = a0;
        b_drv = b0;
        start = 1'b1;
        minl  = 99;
        maxl  = 0;
        for (int i = 0; i < NI; i++) begin
            model(i, a0, b0, exp_res[i], exp_lat[i]);
            if (exp_lat[i] < minl) minl = exp_lat[i];
            if (exp_lat[i] > maxl) maxl = exp_lat[i];
            obs_lat[i] = -1;
            obs_res[i] = 3'b000;
        end
        @(posedge clk);
        for (int n = 0; n <= maxl + 1; n++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                got  = {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]};
                want = {n < exp_lat[i], n == exp_lat[i], (n >= exp_lat[i]) ? exp_res[i] : 3'b000};
                check("cycle", i, got, want);
                if (done_w[i] && obs_lat[i] < 0) begin
                    obs_lat[i] = n;
                    obs_res[i] = {eq_w[i], gt_w[i], lt_w[i]};
                end
            end
            // Start and operands toggling during RUN/DONE must be ignored.
            if (hold && n < minl) begin
                start = 1'b1;
                a_drv = 8'($urandom);
                b_drv = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] r1, r2;
        rst_n = 1'b0;
        start = 1'b0;
        a_drv = 8'h00;
        b_drv = 8'h00;

        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++)
                check("in_reset", i, {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]}, 5'b0);
            start = ~start;
            a_drv = 8'($urandom);
            b_drv = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        @(negedge clk);
        a_drv = 8'h3C;
        b_drv = 8'hC3;
        start = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++)
            check("mid_busy", i, {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]}, 5'b10000);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++)
            check("mid_reset", i, {busy_w[i], done_w[i], eq_w[i], gt_w[i], lt_w[i]}, 5'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        run_op(8'hA5, 8'hA5, 1'b0);
        check_lit("a5_eq_u", 0, 3'b100, 4);
        check_lit("a5_eq_s", 1, 3'b100, 4);

        run_op(8'h80, 8'h7F, 1'b0);
        check_lit("80_7f_u", 0, 3'b010, EARLY ? 1 : 4);
        check_lit("80_7f_s", 1, 3'b001, EARLY ? 1 : 4);

        run_op(8'hFF, 8'hFE, 1'b0);
        check_lit("ff_fe_u", 0, 3'b010, 4);
        check_lit("ff_fe_s", 1, 3'b010, 4);

        run_op(8'h10, 8'h20, 1'b1);
        check_lit("hold_10_20", 0, 3'b001, EARLY ? 2 : 4);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                r1 = 4'($urandom);
                r2 = 4'($urandom);
                run_op({r1, 4'(ai)}, {r2, 4'(bi)}, $urandom_range(0, 7) == 0);
            end
        end

        for (int r = 0; r < 100; r++)
            run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
